// File: rtl/board_input_pkg.sv
// Shared widths, status-word field positions and helpers for the DE2i-150 board input capture block.
package board_input_pkg;

    localparam int N_BUTTONS  = 4;
    localparam int N_SWITCHES = 18;
    localparam int STATUS_W   = 16;
    localparam int SWITCH_W   = 32;

    localparam int LEVEL_LSB  = 0;
    localparam int STICKY_LSB = 4;
    localparam int COUNT_LSB  = 8;

    typedef struct packed {
        logic [7:0]           press_count;
        logic [N_BUTTONS-1:0] sticky;
        logic [N_BUTTONS-1:0] btn_level;
    } status_t;

    function automatic logic [7:0] popcount(input logic [N_BUTTONS-1:0] v);
        logic [7:0] n;
        n = '0;
        for (int i = 0; i < N_BUTTONS; i++) begin
            n = n + {7'b0, v[i]};
        end
        return n;
    endfunction

endpackage

// File: rtl/input_debouncer.sv
// Two-flop synchronizer plus tick-sampled history debouncer for one raw board input.
// RESET_VAL is the idle level of the raw pin; it is also inverted away so the level reads 1 when active.
module input_debouncer
    import board_input_pkg::*;
#(
    parameter int   N_SAMPLES = 3,
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic reset_n,
    input  logic tick,
    input  logic raw,
    output logic level
);

    logic                 sync_a;
    logic                 sync_b;
    logic                 sample;
    logic [N_SAMPLES-1:0] history;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_a <= RESET_VAL;
            sync_b <= RESET_VAL;
        end else begin
            sync_a <= raw;
            sync_b <= sync_a;
        end
    end

    assign sample = sync_b ^ RESET_VAL;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            history <= '0;
        end else if (tick) begin
            history <= {history[N_SAMPLES-2:0], sample};
        end
    end

    // Flip only once the whole history agrees on the opposite value; any bounce restarts the run.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            level <= 1'b0;
        end else if (history == {N_SAMPLES{~level}}) begin
            level <= ~level;
        end
    end

endmodule

// File: rtl/board_input_capture.sv
// Pushbutton/switch conditioner feeding the PCIe PIO input ports: debounce, sticky press flags, press counter.
// Optional registered irq output is enabled by defining BOARD_INPUT_IRQ_EN.
module board_input_capture
    import board_input_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int N_SAMPLES       = 3
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [N_BUTTONS-1:0]  key_n,
    input  logic [N_SWITCHES-1:0] sw_raw,
    input  logic                  ack_toggle,
    output logic [STATUS_W-1:0]   status_word,
`ifdef BOARD_INPUT_IRQ_EN
    output logic [SWITCH_W-1:0]   switch_word,
    output logic                  irq
`else
    output logic [SWITCH_W-1:0]   switch_word
`endif
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES);

    logic [CW-1:0]         presc;
    logic                  tick;
    logic [N_BUTTONS-1:0]  btn_level;
    logic [N_BUTTONS-1:0]  level_prev;
    logic [N_BUTTONS-1:0]  rise;
    logic [N_BUTTONS-1:0]  sticky;
    logic [7:0]            press_count;
    logic                  ack_q;
    logic                  ack_edge;
    logic [N_SWITCHES-1:0] sw_level;
    status_t               status_s;

    assign tick = (presc == CW'(DEBOUNCE_CYCLES - 1));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            presc <= '0;
        end else begin
            presc <= tick ? '0 : presc + CW'(1);
        end
    end

    // Keys idle high and are active-low, so their synchronizers reset to 1 and the level is inverted.
    for (genvar b = 0; b < N_BUTTONS; b++) begin : g_btn
        input_debouncer #(.N_SAMPLES(N_SAMPLES), .RESET_VAL(1'b1)) u_deb (
            .clk     (clk),
            .reset_n (reset_n),
            .tick    (tick),
            .raw     (key_n[b]),
            .level   (btn_level[b])
        );
    end

    for (genvar s = 0; s < N_SWITCHES; s++) begin : g_sw
        input_debouncer #(.N_SAMPLES(N_SAMPLES), .RESET_VAL(1'b0)) u_deb (
            .clk     (clk),
            .reset_n (reset_n),
            .tick    (tick),
            .raw     (sw_raw[s]),
            .level   (sw_level[s])
        );
    end

    assign rise     = btn_level & ~level_prev;
    assign ack_edge = ack_toggle ^ ack_q;

    // A rise in the same cycle as an ack edge wins, so a press is never lost to the host.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            level_prev  <= '0;
            ack_q       <= 1'b0;
            sticky      <= '0;
            press_count <= '0;
        end else begin
            level_prev  <= btn_level;
            ack_q       <= ack_toggle;
            sticky      <= (ack_edge ? '0 : sticky) | rise;
            press_count <= press_count + popcount(rise);
        end
    end

    assign status_s.press_count = press_count;
    assign status_s.sticky      = sticky;
    assign status_s.btn_level   = btn_level;
    assign status_word          = status_s;
    assign switch_word          = {{(SWITCH_W - N_SWITCHES){1'b0}}, sw_level};

`ifdef BOARD_INPUT_IRQ_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            irq <= 1'b0;
        end else begin
            irq <= |sticky;
        end
    end
`endif

endmodule

// File: tb/tb_board_input_capture.sv
// Scoreboard bench for board_input_capture: stimulus pushes the expected sequence of output words,
// a negedge monitor pops one entry each time status_word or switch_word changes.
module tb_board_input_capture;
    import board_input_pkg::*;

    localparam int DC  = 4;
    localparam int NS  = 3;
    localparam int LAT = NS * DC + 6;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [3:0]  key_n;
    logic [17:0] sw_raw;
    logic        ack_toggle;
    logic [15:0] status_word;
    logic [31:0] switch_word;
`ifdef BOARD_INPUT_IRQ_EN
    logic        irq;
`endif

    always #5 clk = ~clk;

    board_input_capture #(.DEBOUNCE_CYCLES(DC), .N_SAMPLES(NS)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .key_n       (key_n),
        .sw_raw      (sw_raw),
        .ack_toggle  (ack_toggle),
        .status_word (status_word),
`ifdef BOARD_INPUT_IRQ_EN
        .switch_word (switch_word),
        .irq         (irq)
`else
        .switch_word (switch_word)
`endif
    );

    int          checks = 0;
    int          errors = 0;
    logic [15:0] exp_status_q[$];
    logic [31:0] exp_switch_q[$];

    // Behavioural model: what the host should see, in terms of presses, acks and switch settings.
    int          m_count;
    logic [3:0]  m_sticky;
    logic [3:0]  m_level;
    logic [17:0] m_sw;

    logic [15:0] last_status;
    logic [31:0] last_switch;

    function automatic logic [15:0] model_status();
        return {8'(m_count), m_sticky, m_level};
    endfunction

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (reset_n !== 1'b1) begin
            last_status = status_word;
            last_switch = switch_word;
        end else begin
            if (status_word !== last_status) begin
                if (exp_status_q.size() == 0) check_output("unexpected status change", 32'(status_word), 32'(last_status));
                else check_output("status event", 32'(status_word), 32'(exp_status_q.pop_front()));
                last_status = status_word;
            end
            if (switch_word !== last_switch) begin
                if (exp_switch_q.size() == 0) check_output("unexpected switch change", switch_word, last_switch);
                else check_output("switch event", switch_word, exp_switch_q.pop_front());
                last_switch = switch_word;
            end
        end
    end

    task automatic push_status();
        exp_status_q.push_back(model_status());
    endtask

    task automatic wait_drain(input int max_cycles, input string name);
        int i = 0;
        while ((exp_status_q.size() + exp_switch_q.size()) != 0 && i < max_cycles) begin
            @(negedge clk);
            #1;
            i++;
        end
        check_output({name, " pending events"}, 32'(exp_status_q.size() + exp_switch_q.size()), 32'd0);
        exp_status_q.delete();
        exp_switch_q.delete();
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic do_reset(input logic [3:0] keys);
        @(negedge clk);
        reset_n    = 1'b0;
        key_n      = keys;
        sw_raw     = '0;
        ack_toggle = 1'b0;
        exp_status_q.delete();
        exp_switch_q.delete();
        m_count  = 0;
        m_sticky = '0;
        m_level  = '0;
        m_sw     = '0;
        step(3);
        check_output("reset status_word", 32'(status_word), 32'd0);
        check_output("reset switch_word", switch_word, 32'd0);
        if (~keys != 4'h0) begin
            m_level = ~keys;
            push_status();
            m_count  = $countones(~keys);
            m_sticky = ~keys;
            push_status();
        end
        reset_n = 1'b1;
        wait_drain(LAT, "reset release");
    endtask

    task automatic press(input int b);
        key_n[b] = 1'b0;
        m_level[b] = 1'b1;
        push_status();
        m_count     = (m_count + 1) % 256;
        m_sticky[b] = 1'b1;
        push_status();
        wait_drain(LAT, "press");
    endtask

    task automatic release_btn(input int b);
        key_n[b] = 1'b1;
        m_level[b] = 1'b0;
        push_status();
        wait_drain(LAT, "release");
    endtask

    task automatic ack();
        ack_toggle = ~ack_toggle;
        if (m_sticky != 4'h0) begin
            m_sticky = '0;
            push_status();
        end
        step(1);
        check_output("ack clear latency", 32'(status_word), 32'(model_status()));
        wait_drain(3, "ack");
    endtask

    task automatic set_switches(input logic [17:0] v);
        sw_raw = v;
        if (v != m_sw) exp_switch_q.push_back({14'b0, v});
        m_sw = v;
        wait_drain(LAT, "switch change");
    endtask

    task automatic glitch(input int b);
        sw_raw[b] = ~sw_raw[b];
        step(1);
        sw_raw[b] = ~sw_raw[b];
        step(NS * DC + 4);
        check_output("switch glitch ignored", switch_word, {14'b0, m_sw});
    endtask

    task automatic set_vs_clear(input int b);
        bit seen = 0;
        key_n[b] = 1'b0;
        m_level[b] = 1'b1;
        push_status();
        for (int i = 0; i < LAT && !seen; i++) begin
            @(negedge clk);
            if (status_word[LEVEL_LSB + b]) seen = 1;
        end
        if (seen) begin
            ack_toggle = ~ack_toggle;
            m_count  = (m_count + 1) % 256;
            m_sticky = 4'h0;
            m_sticky[b] = 1'b1;
            push_status();
        end
        check_output("set/clear level seen", 32'(seen), 32'd1);
        wait_drain(4, "set/clear");
    endtask

    task automatic apply_stimulus();
        int b;
        for (int n = 0; n < 40; n++) begin
            case ($urandom_range(0, 5))
                0, 1: begin
                    b = $urandom_range(0, 3);
                    if (m_level[b]) release_btn(b);
                    else press(b);
                end
                2: ack();
                3: set_switches(18'($urandom));
                4: glitch($urandom_range(0, 17));
                default: step($urandom_range(1, 10));
            endcase
        end
    endtask

    initial begin
        reset_n    = 1'b0;
        key_n      = 4'hF;
        sw_raw     = '0;
        ack_toggle = 1'b0;

        $display("[TB] reset with all keys held");
        do_reset(4'h0);
        check_output("held keys after reset", 32'(status_word), 32'h04FF);

        $display("[TB] clean press and ack");
        do_reset(4'hF);
        press(2);
        check_output("clean press word", 32'(status_word), 32'h0144);
        ack();
        check_output("ack word", 32'(status_word), 32'h0104);
        release_btn(2);

        $display("[TB] bouncing key");
        do_reset(4'hF);
        for (int i = 0; i < 10; i++) begin
            key_n[0] = ~key_n[0];
            step(3);
        end
        key_n[0] = 1'b1;
        step(20);
        check_output("bounce rejected", 32'(status_word), 32'h0000);

        $display("[TB] set versus clear");
        press(0);
        press(3);
        set_vs_clear(1);
        check_output("sticky after set/clear", 32'(status_word[STICKY_LSB +: 4]), 32'h2);
        release_btn(0);
        release_btn(1);
        release_btn(3);

        $display("[TB] press counter wrap");
        do_reset(4'hF);
        for (int i = 0; i < 256; i++) begin
            press(3);
            release_btn(3);
        end
        check_output("count after 256", 32'(status_word[COUNT_LSB +: 8]), 32'h00);
        press(3);
        release_btn(3);
        check_output("count after 257", 32'(status_word[COUNT_LSB +: 8]), 32'h01);

        $display("[TB] switches");
        do_reset(4'hF);
        set_switches(18'h2A5A5);
        check_output("switch word", switch_word, 32'h0002A5A5);
        glitch(0);

        $display("[TB] randomized traffic");
        apply_stimulus();
        step(LAT);
        check_output("final status", 32'(status_word), 32'(model_status()));
        check_output("final switches", switch_word, {14'b0, m_sw});

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/board_input_capture.md
# board_input_capture

Board-side conditioner for the DE2i-150 pushbuttons and slide switches; produces the 16-bit status word and 32-bit switch word that the host reads through the PCIe PIO input ports. Raw inputs are synchronized and debounced. Button presses are latched into sticky flags and counted. The host acknowledges the flags by toggling one bit of a PIO output port, which closes the write-side/read-side handshake.

## Interface
- DEBOUNCE_CYCLES, 50000, clock cycles between debounce samples (1 ms at 50 MHz); legal range 2..2^20
- N_SAMPLES, 3, consecutive equal samples required to change a debounced level; legal range 2..8
- clk  in  1  system clock, same clock as the PIO slaves
- reset_n  in  1  reset, asynchronous assert, active-low
- key_n  in  4  raw pushbuttons, active-low, asynchronous to clk
- sw_raw  in  18  raw slide switches, asynchronous to clk
- ack_toggle  in  1  host acknowledge; any change of level clears the sticky flags; synchronous to clk
- status_word  out  16  {press_count[7:0], sticky[3:0], btn_level[3:0]}, drives the inport PIO input
- switch_word  out  32  {14'b0, sw_level[17:0]}, drives the switches PIO input

## Operation
- Synchronizer: two flops per raw bit. key_n flops reset to 1, sw_raw flops reset to 0.
- Prescaler: counts 0..DEBOUNCE_CYCLES-1 and wraps. Emits a one-cycle tick when it wraps.
- Debouncer, one per bit (22 total):
  - On each tick, the synchronized bit shifts into an N_SAMPLES-deep history.
  - The level updates only when all N_SAMPLES history entries equal the opposite of the current level. Otherwise the level holds.
  - Button level = inverted key_n, so 1 means pressed.
- rise[i] = btn_level[i] now 1 and was 0 in the previous cycle.
- sticky[i] is set by rise[i]. It is cleared when ack_toggle differs from its registered copy (ack edge).
  - Set and clear in the same cycle: the bit ends up set. A press is never lost.
  - Bits with no rise are cleared normally.
- press_count = press_count + popcount(rise), modulo 256. It wraps from 255 to 0 silently and is never cleared by ack.
- Reset values: status_word = 0, switch_word = 0, prescaler = 0, all histories and levels = 0, ack copy = 0.
- A reset mid-debounce discards partial histories. After release, a held button needs a full N_SAMPLES ticks before it reports.

## Timing
- Raw edge to synchronized value: 2 cycles.
- Synchronized value to level change: N_SAMPLES ticks, then +1 cycle for the register.
  - Worst case: N_SAMPLES×DEBOUNCE_CYCLES + 3 cycles.
- Level rise to sticky/press_count update: 1 cycle. Both update in the same cycle.
- ack_toggle edge to sticky clear: 1 cycle.
- All outputs are registered. There is no combinational path from inputs to outputs.
- Glitches shorter than one tick period, or bouncing that breaks a run of N_SAMPLES equal samples, never reach the level.

## Configuration
- BOARD_INPUT_IRQ_EN defined: adds output irq (1 bit, registered, reset 0).
  - irq = 1 in the cycle after any sticky bit is 1.
  - irq = 0 in the cycle after all sticky bits are 0.
- Macro undefined: the irq port and its logic are absent. Polling behaviour is identical.

## Structure
- Package board_input_pkg holds:
  - Widths: N_BUTTONS=4, N_SWITCHES=18, STATUS_W=16, SWITCH_W=32.
  - Field LSB constants: LEVEL_LSB=0, STICKY_LSB=4, COUNT_LSB=8.
  - A packed struct typedef for status_word.
- Sub-module input_debouncer holds the synchronizer, history and level for one bit. It takes the shared tick and a reset-value parameter. It is instantiated 22 times.
- The prescaler, edge detect, sticky flags, counter and ack logic live in the top.

## Test plan
Bench parameters: DEBOUNCE_CYCLES=4, N_SAMPLES=3.
- Reset: hold reset_n=0 with key_n=4'h0 -> status_word=16'h0000 and switch_word=0. After release, btn_level=4'hF within 3×4+3 cycles, sticky=4'hF, press_count=4.
- Clean press: key_n[2] 1→0 held for 40 cycles -> status_word=16'h0144. ack_toggle 0→1 -> status_word=16'h0104 one cycle later.
- Bounce: key_n[0] toggles every 3 cycles for 30 cycles, then returns to 1 -> status_word stays 16'h0000 throughout.
- Set-versus-clear: rise on button 1 in the same cycle as an ack edge -> sticky[1]=1 and the other sticky bits=0.
- Wrap: 256 press/release cycles on button 3 -> press_count returns to 8'h00; 257 cycles -> 8'h01.
- Switches: sw_raw=18'h2A5A5 stable -> switch_word=32'h0002A5A5 after ≤15 cycles. A 1-cycle glitch on sw_raw[0] -> no change.
